// File: rtl/etile_result_dispatcher_if.sv
// ---------------------------------------------------------------------------
// etile_result_dispatcher_if
// Bundles the three traffic groups of the E-tile result dispatcher:
//   res_*  : result offer from the ALU (valid/ready, data, per-target routing)
//   net_*  : operand-network request channel (req/ack plus payload)
//   wq_*   : register W-queue write channel (req/ack plus payload)
// Modports:
//   master : the tile environment (ALU + networks); drives results and acks
//   slave  : the dispatcher; drives res_ready and both request channels
// ---------------------------------------------------------------------------
interface etile_result_dispatcher_if #(
    parameter int DATA_W      = 32,
    parameter int INSTR_W     = 7,
    parameter int NUM_TARGETS = 4
);
    logic                           res_valid;
    logic                           res_ready;
    logic [DATA_W-1:0]              res_data;
    logic [NUM_TARGETS-1:0]         res_tgt_valid;
    logic [NUM_TARGETS-1:0]         res_tgt_is_wq;
    logic [NUM_TARGETS*INSTR_W-1:0] res_tgt_instr;
    logic [NUM_TARGETS*2-1:0]       res_tgt_slot;

    logic                           net_req;
    logic [DATA_W-1:0]              net_data;
    logic [INSTR_W-1:0]             net_dest_instr;
    logic [1:0]                     net_dest_slot;
    logic [INSTR_W-1:0]             net_src;
    logic                           net_ack;

    logic                           wq_req;
    logic [4:0]                     wq_id;
    logic [DATA_W-1:0]              wq_data;
    logic                           wq_ack;

    modport master (
        output res_valid, res_data, res_tgt_valid, res_tgt_is_wq,
               res_tgt_instr, res_tgt_slot, net_ack, wq_ack,
        input  res_ready, net_req, net_data, net_dest_instr, net_dest_slot,
               net_src, wq_req, wq_id, wq_data
    );

    modport slave (
        input  res_valid, res_data, res_tgt_valid, res_tgt_is_wq,
               res_tgt_instr, res_tgt_slot, net_ack, wq_ack,
        output res_ready, net_req, net_data, net_dest_instr, net_dest_slot,
               net_src, wq_req, wq_id, wq_data
    );
endinterface

// File: rtl/etile_result_dispatcher.sv
// ---------------------------------------------------------------------------
// etile_result_dispatcher
// Buffers fired ALU results in a FIFO and delivers each one to up to
// NUM_TARGETS targets over two concurrent req/ack channels (operand network
// and W queue). Each entry keeps a pending mask; a target's bit clears on
// its handshake and the head retires once the mask is empty. Requests are
// retried until acknowledged. flush discards everything buffered.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   flush      : revitalize/squash, clears FIFO and all pending state
//   bus        : result / network / W-queue signals (slave modport)
//   occupancy  : number of buffered results
//   busy       : occupancy != 0
// ---------------------------------------------------------------------------
module etile_result_dispatcher #(
    parameter int DATA_W      = 32,
    parameter int INSTR_W     = 7,
    parameter int NUM_TARGETS = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int NODE_ID     = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    etile_result_dispatcher_if.slave    bus,
    output logic [$clog2(FIFO_DEPTH):0] occupancy,
    output logic                        busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int TGT_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    // FIFO storage; only the pending masks need a reset value
    logic [DATA_W-1:0]              data_mem_r  [FIFO_DEPTH];
    logic [NUM_TARGETS-1:0]         wq_mem_r    [FIFO_DEPTH];
    logic [NUM_TARGETS*INSTR_W-1:0] instr_mem_r [FIFO_DEPTH];
    logic [NUM_TARGETS*2-1:0]       slot_mem_r  [FIFO_DEPTH];
    logic [NUM_TARGETS-1:0]         pend_r      [FIFO_DEPTH];

    logic [PTR_W-1:0]       head_r;
    logic [PTR_W-1:0]       tail_r;
    logic [OCC_W-1:0]       occ_r;

    logic                   head_valid_s;
    logic [NUM_TARGETS-1:0] head_pend_s;
    logic [NUM_TARGETS-1:0] head_wq_s;
    logic                   net_found_s;
    logic                   wq_found_s;
    logic [TGT_W-1:0]       net_sel_s;
    logic [TGT_W-1:0]       wq_sel_s;
    logic                   net_fire_s;
    logic                   wq_fire_s;
    logic [NUM_TARGETS-1:0] net_clr_s;
    logic [NUM_TARGETS-1:0] wq_clr_s;
    logic [NUM_TARGETS-1:0] pend_next_s;
    logic                   push_s;
    logic                   pop_s;

    // res_ready depends only on registered occupancy, so a pop cannot make
    // room for a push in the same cycle
    assign bus.res_ready = (occ_r < OCC_FULL);
    assign push_s        = bus.res_valid && bus.res_ready;
    assign occupancy     = occ_r;
    assign busy          = head_valid_s;
    assign bus.net_src   = INSTR_W'(NODE_ID);

    // Head target selection: lowest pending index per channel. Scanning from
    // the top down lets the lowest match be the last one written.
    always_comb begin
        head_valid_s = (occ_r != '0);
        head_pend_s  = head_valid_s ? pend_r[head_r] : '0;
        head_wq_s    = wq_mem_r[head_r];
        net_found_s  = 1'b0;
        wq_found_s   = 1'b0;
        net_sel_s    = '0;
        wq_sel_s     = '0;
        for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
            net_sel_s   = (head_pend_s[i] && !head_wq_s[i]) ? TGT_W'(i) : net_sel_s;
            wq_sel_s    = (head_pend_s[i] &&  head_wq_s[i]) ? TGT_W'(i) : wq_sel_s;
            net_found_s = net_found_s | (head_pend_s[i] & ~head_wq_s[i]);
            wq_found_s  = wq_found_s  | (head_pend_s[i] &  head_wq_s[i]);
        end
    end

    // Request channels: payloads are forced to zero while req is low
    always_comb begin
        bus.net_req = head_valid_s && net_found_s;
        bus.wq_req  = head_valid_s && wq_found_s;
        if (bus.net_req) begin
            bus.net_data       = data_mem_r[head_r];
            bus.net_dest_instr = instr_mem_r[head_r][net_sel_s*INSTR_W +: INSTR_W];
            bus.net_dest_slot  = slot_mem_r[head_r][net_sel_s*2 +: 2];
        end else begin
            bus.net_data       = '0;
            bus.net_dest_instr = '0;
            bus.net_dest_slot  = 2'd0;
        end
        if (bus.wq_req) begin
            bus.wq_data = data_mem_r[head_r];
            bus.wq_id   = instr_mem_r[head_r][wq_sel_s*INSTR_W +: 5];
        end else begin
            bus.wq_data = '0;
            bus.wq_id   = 5'd0;
        end
    end

    // Handshakes clear their target bits; head retires when nothing is left
    always_comb begin
        net_fire_s  = bus.net_req && bus.net_ack;
        wq_fire_s   = bus.wq_req && bus.wq_ack;
        net_clr_s   = net_fire_s ? (NUM_TARGETS'(1) << net_sel_s) : '0;
        wq_clr_s    = wq_fire_s  ? (NUM_TARGETS'(1) << wq_sel_s)  : '0;
        pend_next_s = head_pend_s & ~net_clr_s & ~wq_clr_s;
        pop_s       = head_valid_s && (pend_next_s == '0);
    end

    // Pointers, occupancy and pending masks; reset and flush dominate
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_r <= '0;
            tail_r <= '0;
            occ_r  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pend_r[i] <= '0;
            end
        end else begin
            // head write first: the tail write may only alias it when empty
            if (head_valid_s) begin
                pend_r[head_r] <= pend_next_s;
            end
            if (push_s) begin
                pend_r[tail_r] <= bus.res_tgt_valid;
                tail_r         <= tail_r + PTR_ONE;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + OCC_ONE;
                2'b01:   occ_r <= occ_r - OCC_ONE;
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Result payload storage, written on an accepted push
    always_ff @(posedge clk) begin
        if (push_s && !rst && !flush) begin
            data_mem_r[tail_r]  <= bus.res_data;
            wq_mem_r[tail_r]    <= bus.res_tgt_is_wq;
            instr_mem_r[tail_r] <= bus.res_tgt_instr;
            slot_mem_r[tail_r]  <= bus.res_tgt_slot;
        end
    end
endmodule

// File: tb/tb_etile_result_dispatcher.sv
// Testbench for etile_result_dispatcher: a per-cycle queue model of the
// buffered entries predicts every output, a vector table covers single-result
// routing, and short sequences cover back-pressure, full FIFO, zero-target
// entries, flush and random wrap-around traffic.
module tb_etile_result_dispatcher;
    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [2:0] occupancy;
    logic       busy;

    etile_result_dispatcher_if #(.DATA_W(32), .INSTR_W(7), .NUM_TARGETS(4)) bus ();

    etile_result_dispatcher #(
        .DATA_W(32), .INSTR_W(7), .NUM_TARGETS(4), .FIFO_DEPTH(4), .NODE_ID(0)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus),
        .occupancy(occupancy), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  pend;
        logic [3:0]  isw;
        logic [27:0] instr;
        logic [7:0]  slot;
    } ent_t;
    ent_t mq[$];

    int dut_net_xfers, dut_wq_xfers, net_pushed, wq_pushed;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tv;
        logic [3:0]  isw;
        logic [27:0] instr;
        logic [7:0]  slot;
        logic        e_nreq;
        logic [6:0]  e_ninstr;
        logic [1:0]  e_nslot;
        logic        e_wreq;
        logic [4:0]  e_wid;
        int          e_cycles;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Predict outputs from the model queue, compare, then advance the model
    // by the coming clock edge using the inputs the bench is driving.
    task automatic model_step();
        logic enr, ewr, push_ok, pop;
        int   ni, wi, sz;
        ent_t h, e;
        enr = 1'b0; ewr = 1'b0; ni = 0; wi = 0; pop = 1'b0;
        sz = mq.size();
        h = '{default: '0};
        if (sz > 0) begin
            h = mq[0];
            for (int i = 3; i >= 0; i--) begin
                if (h.pend[i] && !h.isw[i]) begin enr = 1'b1; ni = i; end
                if (h.pend[i] &&  h.isw[i]) begin ewr = 1'b1; wi = i; end
            end
        end
        chk("res_ready", bus.res_ready, sz < 4);
        chk("occupancy", occupancy, sz);
        chk("busy", busy, sz > 0);
        chk("net_req", bus.net_req, enr);
        chk("wq_req", bus.wq_req, ewr);
        chk("net_data", bus.net_data, enr ? h.data : 32'd0);
        chk("net_dest_instr", bus.net_dest_instr, enr ? h.instr[ni*7 +: 7] : 7'd0);
        chk("net_dest_slot", bus.net_dest_slot, enr ? h.slot[ni*2 +: 2] : 2'd0);
        chk("net_src", bus.net_src, 32'd0);
        chk("wq_id", bus.wq_id, ewr ? h.instr[wi*7 +: 5] : 5'd0);
        chk("wq_data", bus.wq_data, ewr ? h.data : 32'd0);
        if (!rst && !flush) begin
            if (bus.net_req && bus.net_ack) dut_net_xfers++;
            if (bus.wq_req && bus.wq_ack)   dut_wq_xfers++;
        end
        if (rst || flush) begin
            mq.delete();
        end else begin
            push_ok = bus.res_valid && (sz < 4);
            if (sz > 0) begin
                if (enr && bus.net_ack) h.pend[ni] = 1'b0;
                if (ewr && bus.wq_ack)  h.pend[wi] = 1'b0;
                mq[0] = h;
                pop = (h.pend == 4'd0);
            end
            if (pop) mq.delete(0);
            if (push_ok) begin
                e.data  = bus.res_data;
                e.pend  = bus.res_tgt_valid;
                e.isw   = bus.res_tgt_is_wq;
                e.instr = bus.res_tgt_instr;
                e.slot  = bus.res_tgt_slot;
                mq.push_back(e);
                net_pushed += $countones(e.pend & ~e.isw);
                wq_pushed  += $countones(e.pend & e.isw);
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_res(input logic v, input logic [31:0] d, input logic [3:0] tv,
                           input logic [3:0] isw, input logic [27:0] instr, input logic [7:0] slot);
        bus.res_valid     = v;
        bus.res_data      = d;
        bus.res_tgt_valid = tv;
        bus.res_tgt_is_wq = isw;
        bus.res_tgt_instr = instr;
        bus.res_tgt_slot  = slot;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        bus.net_ack = 1'b1;
        bus.wq_ack  = 1'b1;
        while (busy && n < budget) begin
            cycle();
            n++;
        end
        chk(name, busy, 1'b0);
    endtask

    initial begin
        int n, pushed, guard;
        logic v;
        logic [7:0] sl;

        vecs[0] = '{32'h1234, 4'b0011, 4'b0000, {7'd0, 7'd0, 7'd9, 7'd5},
                    {2'd0, 2'd0, 2'd0, 2'd1}, 1'b1, 7'd5, 2'd1, 1'b0, 5'd0, 2};
        vecs[1] = '{32'h00AB_CDEF, 4'b0011, 4'b0001, {7'd0, 7'd0, 7'd3, 7'h23},
                    {2'd0, 2'd0, 2'd2, 2'd0}, 1'b1, 7'd3, 2'd2, 1'b1, 5'd3, 1};
        vecs[2] = '{32'h55, 4'b0000, 4'b0000, 28'd0, 8'd0,
                    1'b0, 7'd0, 2'd0, 1'b0, 5'd0, 1};
        vecs[3] = '{32'hDEAD_BEEF, 4'b1111, 4'b0110, {7'h7F, 7'h1F, 7'h41, 7'd10},
                    {2'd2, 2'd0, 2'd0, 2'd0}, 1'b1, 7'd10, 2'd0, 1'b1, 5'd1, 2};
        vecs[4] = '{32'h0F0F_0F0F, 4'b1100, 4'b1000, {7'd6, 7'd20, 7'd0, 7'd33},
                    {2'd0, 2'd1, 2'd0, 2'd2}, 1'b1, 7'd20, 2'd1, 1'b1, 5'd6, 1};

        rst = 1'b1; flush = 1'b0;
        bus.net_ack = 1'b0; bus.wq_ack = 1'b0;
        set_res(1'b0, 32'd0, 4'd0, 4'd0, 28'd0, 8'd0);
        dut_net_xfers = 0; dut_wq_xfers = 0; net_pushed = 0; wq_pushed = 0;
        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_res_ready", bus.res_ready, 1'b1);
        chk("rst_net_req", bus.net_req, 1'b0);
        chk("rst_wq_req", bus.wq_req, 1'b0);
        chk("rst_occupancy", occupancy, 3'd0);
        chk("rst_busy", busy, 1'b0);

        // single results into an empty FIFO with both acks tied high
        for (int k = 0; k < 5; k++) begin
            bus.net_ack = 1'b1; bus.wq_ack = 1'b1;
            set_res(1'b1, vecs[k].data, vecs[k].tv, vecs[k].isw, vecs[k].instr, vecs[k].slot);
            cycle();
            bus.res_valid = 1'b0;
            chk("vec_occupancy", occupancy, 3'd1);
            chk("vec_net_req", bus.net_req, vecs[k].e_nreq);
            chk("vec_net_instr", bus.net_dest_instr, vecs[k].e_ninstr);
            chk("vec_net_slot", bus.net_dest_slot, vecs[k].e_nslot);
            chk("vec_net_data", bus.net_data, vecs[k].e_nreq ? vecs[k].data : 32'd0);
            chk("vec_wq_req", bus.wq_req, vecs[k].e_wreq);
            chk("vec_wq_id", bus.wq_id, vecs[k].e_wid);
            n = 0;
            while (busy && n < 20) begin
                cycle();
                n++;
            end
            chk("vec_cycles_to_empty", n, vecs[k].e_cycles);
        end

        // back-pressure: request and payload hold while net_ack stays low
        bus.net_ack = 1'b0; bus.wq_ack = 1'b0;
        set_res(1'b1, 32'hCAFE, 4'b0001, 4'b0000, {21'd0, 7'd7}, {6'd0, 2'd2});
        cycle();
        bus.res_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_net_req", bus.net_req, 1'b1);
            chk("bp_net_instr", bus.net_dest_instr, 7'd7);
            chk("bp_net_slot", bus.net_dest_slot, 2'd2);
            chk("bp_net_data", bus.net_data, 32'hCAFE);
            cycle();
        end
        chk("bp_occupancy", occupancy, 3'd1);
        bus.net_ack = 1'b1;
        cycle();
        chk("bp_popped", busy, 1'b0);

        // full FIFO: no push while full, even on the popping cycle
        bus.net_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_res(1'b1, 32'h100 + k, 4'b0001, 4'b0000, {21'd0, 7'(k + 1)}, 8'd0);
            cycle();
        end
        chk("full_occupancy", occupancy, 3'd4);
        chk("full_res_ready", bus.res_ready, 1'b0);
        set_res(1'b1, 32'h104, 4'b0001, 4'b0000, {21'd0, 7'd5}, 8'd0);
        bus.net_ack = 1'b1;
        cycle();
        bus.net_ack = 1'b0;
        chk("full_pop_no_push", occupancy, 3'd3);
        chk("full_ready_again", bus.res_ready, 1'b1);
        cycle();
        bus.res_valid = 1'b0;
        chk("full_fifth_accepted", occupancy, 3'd4);
        drain("full_drain", 40);

        // zero-target entry retires silently, next entry requests right after
        bus.net_ack = 1'b1; bus.wq_ack = 1'b1;
        set_res(1'b1, 32'hAA, 4'b0000, 4'b0000, 28'd0, 8'd0);
        cycle();
        set_res(1'b1, 32'hBB, 4'b0001, 4'b0000, {21'd0, 7'd12}, {6'd0, 2'd1});
        chk("zero_busy", busy, 1'b1);
        chk("zero_no_net_req", bus.net_req, 1'b0);
        chk("zero_no_wq_req", bus.wq_req, 1'b0);
        cycle();
        bus.res_valid = 1'b0;
        chk("zero_next_req", bus.net_req, 1'b1);
        chk("zero_next_instr", bus.net_dest_instr, 7'd12);
        chk("zero_next_data", bus.net_data, 32'hBB);
        chk("zero_next_occ", occupancy, 3'd1);
        cycle();
        chk("zero_done", busy, 1'b0);

        // flush with three buffered entries, an ack and a push in the same cycle
        bus.net_ack = 1'b0; bus.wq_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_res(1'b1, 32'h200 + k, 4'b0011, 4'b0010,
                    {7'd0, 7'd0, 7'(k + 40), 7'(k + 20)}, 8'd0);
            cycle();
        end
        chk("flush_pre_occ", occupancy, 3'd3);
        flush = 1'b1; bus.net_ack = 1'b1; bus.wq_ack = 1'b1;
        set_res(1'b1, 32'h2FF, 4'b0001, 4'b0000, {21'd0, 7'd9}, 8'd0);
        cycle();
        flush = 1'b0; bus.res_valid = 1'b0; bus.net_ack = 1'b0; bus.wq_ack = 1'b0;
        chk("flush_occupancy", occupancy, 3'd0);
        chk("flush_net_req", bus.net_req, 1'b0);
        chk("flush_wq_req", bus.wq_req, 1'b0);
        chk("flush_busy", busy, 1'b0);
        cycle();
        chk("flush_push_dropped", occupancy, 3'd0);

        // wrap-around: 12 random results with random acks
        dut_net_xfers = 0; dut_wq_xfers = 0; net_pushed = 0; wq_pushed = 0;
        pushed = 0; guard = 0;
        while (pushed < 12 && guard < 600) begin
            v = ($urandom_range(0, 3) != 0);
            for (int t = 0; t < 4; t++) sl[t*2 +: 2] = 2'($urandom_range(0, 2));
            set_res(v, $urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    28'($urandom), sl);
            bus.net_ack = 1'($urandom_range(0, 1));
            bus.wq_ack  = 1'($urandom_range(0, 1));
            if (v && mq.size() < 4) pushed++;
            cycle();
            guard++;
        end
        bus.res_valid = 1'b0;
        chk("wrap_all_pushed", pushed, 12);
        drain("wrap_drain", 60);
        chk("wrap_net_delivered", dut_net_xfers, net_pushed);
        chk("wrap_wq_delivered", dut_wq_xfers, wq_pushed);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
